// File: rtl/avalon_mm_reg_bank_if.sv
// Avalon-MM bus bundle for avalon_mm_reg_bank.
// Ports: address/chipselect/write/read/writedata/byteenable (master->slave),
//        readdata/readdatavalid/waitrequest (slave->master).
interface avalon_mm_reg_bank_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic [AW-1:0]   address;
    logic            chipselect;
    logic            write;
    logic            read;
    logic [DW-1:0]   writedata;
    logic [DW/8-1:0] byteenable;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;
    logic            waitrequest;

    modport master (
        output address, chipselect, write, read, writedata, byteenable,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, write, read, writedata, byteenable,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avalon_mm_reg_bank.sv
// Avalon-MM slave register bank: RO_BASE r/w control words, then read-only
// status words, with pipelined reads of latency RD_LAT.
// Ports: clk, rst (sync, active-high), bus (Avalon-MM slave modport),
//        ctrl_q/ctrl_wr (control words + write pulses),
//        sts_in/sts_rd (status words + read pulses).
// Macro AVALON_REG_BYTEEN_EN: when defined, byteenable masks write lanes;
// otherwise every accepted write replaces the whole word.
module avalon_mm_reg_bank #(
    parameter int          DW      = 32,
    parameter int          AW      = 4,
    parameter int          REG_NUM = 16,
    parameter int          RO_BASE = 8,
    parameter int          RD_LAT  = 1,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    avalon_mm_reg_bank_if.slave           bus,
    output logic [RO_BASE*DW-1:0]         ctrl_q,
    output logic [RO_BASE-1:0]            ctrl_wr,
    input  logic [(REG_NUM-RO_BASE)*DW-1:0] sts_in,
    output logic [REG_NUM-RO_BASE-1:0]    sts_rd
);
    localparam int ST_N = REG_NUM - RO_BASE;

    logic                 wait_q, wait_d;
    logic                 wr_acc, rd_acc;
    logic [DW-1:0]        rd_word;
    logic [RO_BASE*DW-1:0] ctrl_d;
    logic [RO_BASE-1:0]   ctrl_wr_q, ctrl_wr_d;
    logic [ST_N-1:0]      sts_rd_q, sts_rd_d;
    logic [RD_LAT-1:0]    rd_vld_q, rd_vld_d;
    logic [DW-1:0]        rd_data_q [RD_LAT];
    logic [DW-1:0]        rd_data_d [RD_LAT];

`ifndef AVALON_REG_BYTEEN_EN
    logic unused_be;
    assign unused_be = ^bus.byteenable;
`endif

    // Held high through reset and for one cycle after it drops.
    assign bus.waitrequest   = rst | wait_q;
    assign bus.readdata      = rd_data_q[RD_LAT-1];
    assign bus.readdatavalid = rd_vld_q[RD_LAT-1];
    assign ctrl_wr           = ctrl_wr_q;
    assign sts_rd            = sts_rd_q;

    always_comb begin
        wait_d = 1'b0;
        wr_acc = bus.chipselect & ~bus.waitrequest & bus.write;
        // A simultaneous write wins; the read is dropped.
        rd_acc = bus.chipselect & ~bus.waitrequest & bus.read & ~bus.write;

        ctrl_d    = ctrl_q;
        ctrl_wr_d = '0;
        for (int i = 0; i < RO_BASE; i++) begin
            if (wr_acc && bus.address == AW'(i)) begin
                ctrl_wr_d[i] = 1'b1;
`ifdef AVALON_REG_BYTEEN_EN
                for (int k = 0; k < DW/8; k++) begin
                    if (bus.byteenable[k]) begin
                        ctrl_d[i*DW+k*8 +: 8] = bus.writedata[k*8 +: 8];
                    end
                end
`else
                ctrl_d[i*DW +: DW] = bus.writedata;
`endif
            end
        end

        // Unmapped addresses fall through to zero.
        rd_word  = '0;
        sts_rd_d = '0;
        for (int i = 0; i < RO_BASE; i++) begin
            if (bus.address == AW'(i)) begin
                rd_word = ctrl_q[i*DW +: DW];
            end
        end
        for (int j = 0; j < ST_N; j++) begin
            if (bus.address == AW'(RO_BASE + j)) begin
                rd_word     = sts_in[j*DW +: DW];
                sts_rd_d[j] = rd_acc;
            end
        end

        // Data only moves with a valid token, so the last stage holds the
        // most recent response while readdatavalid is low.
        rd_vld_d[0]  = rd_acc;
        rd_data_d[0] = rd_acc ? rd_word : rd_data_q[0];
        for (int s = 1; s < RD_LAT; s++) begin
            rd_vld_d[s]  = rd_vld_q[s-1];
            rd_data_d[s] = rd_vld_q[s-1] ? rd_data_q[s-1] : rd_data_q[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q    <= 1'b1;
            ctrl_q    <= {RO_BASE{RST_VAL}};
            ctrl_wr_q <= '0;
            sts_rd_q  <= '0;
            rd_vld_q  <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                rd_data_q[s] <= '0;
            end
        end else begin
            wait_q    <= wait_d;
            ctrl_q    <= ctrl_d;
            ctrl_wr_q <= ctrl_wr_d;
            sts_rd_q  <= sts_rd_d;
            rd_vld_q  <= rd_vld_d;
            for (int s = 0; s < RD_LAT; s++) begin
                rd_data_q[s] <= rd_data_d[s];
            end
        end
    end
endmodule
